// File: rtl/cacheline_adapter_pkg.sv
// cacheline_adapter_pkg
// Shared constants and types for the cache-line <-> memory-burst adapter.
//   LINE_W_DEF / BURST_W_DEF : default line and beat widths
//   BEATS                    : beats per line at the default widths
//   CNT_W                    : beat counter width
//   state_t                  : adapter FSM states
//   line_align()             : clears the in-line byte offset of an address
package cacheline_adapter_pkg;

    localparam int unsigned LINE_W_DEF  = 256;
    localparam int unsigned BURST_W_DEF = 64;
    localparam int unsigned BEATS       = LINE_W_DEF / BURST_W_DEF;
    localparam int unsigned CNT_W       = $clog2(BEATS);
    localparam int unsigned ADDR_W      = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DONE,
        WR,
        WR_DONE
    } state_t;

    // A 32-byte line occupies address bits [4:0].
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:5], 5'b0};
    endfunction

endpackage

// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if
// Bundles the cache-side and memory-side signals of the adapter.
//   cache side : line_i, address_i, read_i, write_i  -> adapter
//                line_o, resp_o                      <- adapter
//   memory side: burst_i, resp_i                     -> adapter
//                burst_o, address_o, read_o, write_o <- adapter
//   err_o      : sticky protocol error flag from the adapter
// Modports: slave = adapter view, master = cache/memory (environment) view.
interface cacheline_adapter_if
    import cacheline_adapter_pkg::*;
#(
    parameter int unsigned LINE_W  = LINE_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
);

    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;
    logic               err_o;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o, err_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o, err_o
    );

endinterface

// File: rtl/cacheline_adapter.sv
// cacheline_adapter
// Converts single cache-line fill/writeback requests into BEATS-beat memory
// bursts. A fill collects beats into line_o; a writeback streams the latched
// line out on burst_o. resp_o pulses for one cycle when a request completes.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : cacheline_adapter_if.slave (cache and memory handshakes, err_o)
// Build option:
//   CACHELINE_ADAPTER_ERR_CHECK_EN : enables the sticky err_o protocol check;
//                                    otherwise err_o is tied low.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
#(
    parameter int unsigned LINE_W  = LINE_W_DEF,
    parameter int unsigned BURST_W = BURST_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    cacheline_adapter_if.slave   bus
);

    localparam int unsigned NBEATS = LINE_W / BURST_W;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [LINE_W-1:0]   line_buf;
    logic [LINE_W-1:0]   line_asm;
    logic [ADDR_W-1:0]   addr_q;
    logic                last_beat;

    assign last_beat = bus.resp_i && (cnt == CNT_W'(NBEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory/cache strobes decode straight from the state register so that
    // an asynchronous reset drops them without waiting for a clock edge.
    always_comb begin
        state_next  = state;
        bus.read_o  = 1'b0;
        bus.write_o = 1'b0;
        bus.resp_o  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.write_i) begin
                    state_next = WR;
                end else if (bus.read_i) begin
                    state_next = RD;
                end
            end
            RD: begin
                bus.read_o = 1'b1;
                if (last_beat) begin
                    state_next = RD_DONE;
                end
            end
            WR: begin
                bus.write_o = 1'b1;
                if (last_beat) begin
                    state_next = WR_DONE;
                end
            end
            RD_DONE, WR_DONE: begin
                bus.resp_o = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counter is cleared while idle, so it always starts a burst at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            line_buf <= '0;
            line_asm <= '0;
            addr_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.write_i) begin
                        line_buf <= bus.line_i;
                        addr_q   <= bus.address_i;
                    end else if (bus.read_i) begin
                        addr_q   <= bus.address_i;
                    end
                end
                RD: begin
                    if (bus.resp_i) begin
                        line_asm[BURST_W*cnt +: BURST_W] <= bus.burst_i;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WR: begin
                    if (bus.resp_i) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign bus.line_o    = line_asm;
    assign bus.burst_o   = line_buf[BURST_W*cnt +: BURST_W];
    assign bus.address_o = line_align(addr_q);

`ifdef CACHELINE_ADAPTER_ERR_CHECK_EN
    logic err_q;
    logic err_set;

    // Flags a beat strobe outside a burst, or the committed request being
    // withdrawn before its completion pulse.
    always_comb begin
        err_set = 1'b0;
        if (bus.resp_i && (state != RD) && (state != WR)) begin
            err_set = 1'b1;
        end
        if ((state == RD) && !bus.read_i) begin
            err_set = 1'b1;
        end
        if ((state == WR) && !bus.write_i) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter
// Self-checking bench for cacheline_adapter. A driver issues fill/writeback
// requests and plays the memory side; each request pushes its expected
// outcome into a scoreboard queue, and a monitor checks the DUT against it.
// Honours CACHELINE_ADAPTER_ERR_CHECK_EN for the err_o expectation.
module tb_cacheline_adapter;
    import cacheline_adapter_pkg::*;

    localparam int unsigned LW = LINE_W_DEF;
    localparam int unsigned BW = BURST_W_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cacheline_adapter_if #(.LINE_W(LW), .BURST_W(BW)) bus ();

    cacheline_adapter #(.LINE_W(LW), .BURST_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit           w;
        logic [31:0]  addr;
        logic [255:0] line;
        int           act;
        int           req_cyc;
        bit           exact;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [255:0] last_line = '0;
    int           act_cnt = 0;
    int           bidx = 0;
    bit           prev_resp = 1'b0;
    exp_t         cur;
    logic [255:0] cur_line;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            last_line = '0;
            act_cnt   = 0;
            bidx      = 0;
            prev_resp = 1'b0;
        end else begin
            if (bus.read_o || bus.write_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_burst: read_o=%b write_o=%b required idle",
                             bus.read_o, bus.write_o);
                end else begin
                    chk("burst_kind", {bus.read_o, bus.write_o}, sb[0].w ? 2'b01 : 2'b10);
                    if (bus.write_o && bus.resp_i) begin
                        cur_line = sb[0].line;
                        chk("write_beat", bus.burst_o, cur_line[BW*bidx +: BW]);
                        bidx++;
                    end
                end
                act_cnt++;
            end
            if (bus.resp_o) begin
                chk("resp_single_cycle", prev_resp, 1'b0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: resp_o=1 required 0");
                end else begin
                    cur = sb.pop_front();
                    chk("address_o", bus.address_o, cur.addr);
                    chk("burst_cycles", act_cnt, cur.act);
                    if (cur.exact) chk("latency", cyc - cur.req_cyc, 5);
                    if (!cur.w) begin
                        chk("read_line", bus.line_o, cur.line);
                        last_line = cur.line;
                    end else begin
                        chk("line_o_hold", bus.line_o, last_line);
                        chk("write_beats", bidx, BEATS);
                    end
                end
                act_cnt = 0;
                bidx    = 0;
            end
            prev_resp = bus.resp_o;
        end
    end

    // One request; gmode 0 = back-to-back beats, 1 = one idle cycle before
    // each beat, 2 = random 0..2 idle cycles before each beat.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [255:0] data, input int gmode, input bit exact);
        int   g[4];
        int   tot;
        exp_t e;
        tot = 0;
        for (int k = 0; k < 4; k++) begin
            g[k] = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
            tot += g[k];
        end
        @(posedge clk); #1;
        bus.read_i    = rd;
        bus.write_i   = wr;
        bus.address_i = addr;
        bus.line_i    = wr ? data : {8{$urandom}};
        e.w       = wr;
        e.addr    = (addr / 32) * 32;
        e.line    = data;
        e.act     = BEATS + tot;
        e.req_cyc = cyc;
        e.exact   = exact;
        sb.push_back(e);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            repeat (g[k]) begin
                bus.resp_i  = 1'b0;
                bus.burst_i = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            bus.resp_i  = 1'b1;
            bus.burst_i = data[64*k +: 64];
            @(posedge clk); #1;
        end
        bus.resp_i = 1'b0;
        @(posedge clk); #1;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
    endtask

    logic [255:0] rline;
    logic [255:0] wline;
    int           kind;
    bit           err_exp;

    initial begin
`ifdef CACHELINE_ADAPTER_ERR_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_read_o", bus.read_o, 1'b0);
        chk("rst_write_o", bus.write_o, 1'b0);
        chk("rst_resp_o", bus.resp_o, 1'b0);
        chk("rst_err_o", bus.err_o, 1'b0);
        chk("rst_line_o", bus.line_o, '0);
        chk("rst_address_o", bus.address_o, '0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Directed fill, back-to-back beats.
        rline = {64'h4444444444444444, 64'h3333333333333333,
                 64'h2222222222222222, 64'h1111111111111111};
        run_txn(1'b1, 1'b0, 32'h1234_5678, rline, 0, 1'b1);

        // Directed writeback with a gap before every beat.
        wline = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
        run_txn(1'b0, 1'b1, 32'hCAFE_0047, wline, 1, 1'b0);

        // Both requests at once: writeback must win.
        run_txn(1'b1, 1'b1, 32'h0000_ABCD, {8{$urandom}}, 2, 1'b0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 2));
            run_txn(kind != 1, kind != 0, $urandom, {8{$urandom}}, 2, 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        chk("err_after_legal_traffic", bus.err_o, 1'b0);

        // Beat strobe while idle: no data change; flagged only with the check built in.
        @(posedge clk); #1;
        bus.resp_i  = 1'b1;
        bus.burst_i = {$urandom, $urandom};
        @(posedge clk); #1;
        bus.resp_i  = 1'b0;
        @(posedge clk); #1;
        chk("idle_resp_line_o", bus.line_o, last_line);
        chk("idle_resp_err_o", bus.err_o, err_exp);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", bus.err_o, err_exp);
        run_txn(1'b1, 1'b0, $urandom, {8{$urandom}}, 0, 1'b1);

        // Reset after two beats of a fill.
        @(posedge clk); #1;
        bus.read_i    = 1'b1;
        bus.address_i = 32'h8765_4321;
        cur.w = 1'b0; cur.addr = 32'h8765_4320; cur.line = '0;
        cur.act = 4; cur.req_cyc = cyc; cur.exact = 1'b0;
        sb.push_back(cur);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        bus.resp_i = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("abort_read_o", bus.read_o, 1'b0);
        chk("abort_resp_o", bus.resp_o, 1'b0);
        chk("abort_line_o", bus.line_o, '0);
        chk("abort_address_o", bus.address_o, '0);
        chk("abort_err_o", bus.err_o, 1'b0);
        bus.read_i = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        run_txn(1'b1, 1'b0, 32'h1357_9BDF, {8{$urandom}}, 0, 1'b1);
        run_txn(1'b0, 1'b1, 32'h2468_ACE0, {8{$urandom}}, 2, 1'b0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
